// File: rtl/rv32i_types_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_types
// Shared core-wide constants. Constants only, no typedefs.
//   ISSUE_ALLOC_WIDTH : dispatch lanes that may allocate issue-queue slots
//                       in one cycle.
//   ISSUE_QUEUE_DEPTH : default reservation-station depth.
// ---------------------------------------------------------------------------
package rv32i_types;

    localparam int ISSUE_ALLOC_WIDTH = 2;
    localparam int ISSUE_QUEUE_DEPTH = 8;

endpackage

// File: rtl/issue_queue_alloc_free_slot_finder.sv
// ---------------------------------------------------------------------------
// free_slot_finder
// Combinational multi-lane free-slot picker. Each requesting lane, in lane
// order, takes the lowest slot still free after the lanes below it have
// taken theirs. Once a requesting lane finds no slot, all higher lanes are
// refused so dispatch order is preserved. Non-requesting lanes are skipped.
//
// Ports:
//   free_mask [DEPTH]        1 = slot free
//   req       [WIDTH]        per-lane request (lane 0 oldest)
//   gnt       [WIDTH]        per-lane grant
//   idx       [WIDTH][IDX_W] granted slot per lane, 0 when not granted
// ---------------------------------------------------------------------------
module free_slot_finder
    import rv32i_types::*;
#(
    parameter  int DEPTH = ISSUE_QUEUE_DEPTH,
    parameter  int WIDTH = ISSUE_ALLOC_WIDTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]            free_mask,
    input  logic [WIDTH-1:0]            req,
    output logic [WIDTH-1:0]            gnt,
    output logic [WIDTH-1:0][IDX_W-1:0] idx
);

    logic [DEPTH-1:0] mask;
    logic             blocked;
    logic             found;
    logic [IDX_W-1:0] pick;

    // Cascaded lowest-set-bit search; each grant removes its slot from the
    // mask seen by the next lane.
    always_comb begin
        mask    = free_mask;
        blocked = 1'b0;
        found   = 1'b0;
        pick    = '0;
        gnt     = '0;
        idx     = '0;
        for (int l = 0; l < WIDTH; l++) begin
            found = 1'b0;
            pick  = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && mask[i]) begin
                    found = 1'b1;
                    pick  = i[IDX_W-1:0];
                end
            end
            if (req[l] && !blocked) begin
                if (found) begin
                    gnt[l]     = 1'b1;
                    idx[l]     = pick;
                    mask[pick] = 1'b0;
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/issue_queue_alloc.sv
// ---------------------------------------------------------------------------
// issue_queue_alloc
// Slot allocator for one reservation-station issue queue. Owns the slot
// valid vector, grants up to ALLOC_WIDTH free slots per cycle (lowest index
// first), releases slots on issue or flush and tracks occupancy.
//
// Optional feature macro: ISSUE_AGE_MATRIX_EN
//   When defined, an age matrix (age[i][j] = 1: slot i older than slot j)
//   is kept and the oldest ready slot is reported to select logic. When
//   undefined, the age ports and storage are absent.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   alloc_req      per-lane allocation request, lane 0 oldest
//   alloc_gnt      per-lane grant (combinational, same cycle as request)
//   alloc_idx      per-lane granted slot, 0 when lane not granted
//   free_vect      slots issued this cycle
//   flush          invalidate all slots (wins over alloc and free)
//   valid_vect     registered slot occupancy
//   occupancy      registered valid-slot count
//   queue_full     all slots valid
//   can_accept     at least ALLOC_WIDTH free slots
//   ready_vect     operands-ready per slot          (age matrix only)
//   oldest_valid   a ready valid slot exists        (age matrix only)
//   oldest_idx     oldest ready valid slot          (age matrix only)
// ---------------------------------------------------------------------------
module issue_queue_alloc
    import rv32i_types::*;
#(
    parameter  int QUEUE_DEPTH = ISSUE_QUEUE_DEPTH,
    parameter  int ALLOC_WIDTH = ISSUE_ALLOC_WIDTH,
    localparam int IDX_W       = $clog2(QUEUE_DEPTH),
    localparam int OCC_W       = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [ALLOC_WIDTH-1:0]              alloc_req,
    output logic [ALLOC_WIDTH-1:0]              alloc_gnt,
    output logic [ALLOC_WIDTH-1:0][IDX_W-1:0]   alloc_idx,
    input  logic [QUEUE_DEPTH-1:0]              free_vect,
    input  logic                                flush,
    output logic [QUEUE_DEPTH-1:0]              valid_vect,
    output logic [OCC_W-1:0]                    occupancy,
    output logic                                queue_full,
    output logic                                can_accept
`ifdef ISSUE_AGE_MATRIX_EN
    ,
    input  logic [QUEUE_DEPTH-1:0]              ready_vect,
    output logic                                oldest_valid,
    output logic [IDX_W-1:0]                    oldest_idx
`endif
);

    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(QUEUE_DEPTH);
    localparam logic [OCC_W-1:0] WIDTH_C = OCC_W'(ALLOC_WIDTH);

    function automatic logic [OCC_W-1:0] popcount(input logic [QUEUE_DEPTH-1:0] v);
        logic [OCC_W-1:0] c;
        c = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            c = c + OCC_W'(v[i]);
        end
        return c;
    endfunction

    logic [ALLOC_WIDTH-1:0]            fs_gnt;
    logic [ALLOC_WIDTH-1:0][IDX_W-1:0] fs_idx;
    logic [QUEUE_DEPTH-1:0]            granted_mask;
    logic [QUEUE_DEPTH-1:0]            valid_nxt;

    // Grants look only at the registered valid vector, so a slot freed this
    // cycle becomes grantable next cycle.
    free_slot_finder #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ALLOC_WIDTH)
    ) u_finder (
        .free_mask (~valid_vect),
        .req       (alloc_req),
        .gnt       (fs_gnt),
        .idx       (fs_idx)
    );

    // Grants are suppressed while reset is held, even though the empty
    // queue would otherwise grant.
    assign alloc_gnt = rst_n ? fs_gnt : '0;
    assign alloc_idx = rst_n ? fs_idx : '0;

    always_comb begin
        granted_mask = '0;
        for (int l = 0; l < ALLOC_WIDTH; l++) begin
            if (fs_gnt[l]) begin
                granted_mask[fs_idx[l]] = 1'b1;
            end
        end
    end

    assign valid_nxt  = flush ? '0 : ((valid_vect & ~free_vect) | granted_mask);
    assign queue_full = &valid_vect;
    // occupancy never exceeds QUEUE_DEPTH, so the subtraction cannot wrap.
    assign can_accept = (DEPTH_C - occupancy) >= WIDTH_C;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_vect <= '0;
            occupancy  <= '0;
        end else begin
            valid_vect <= valid_nxt;
            occupancy  <= popcount(valid_nxt);
        end
    end

    // Issuing a slot that holds no instruction indicates a select-logic bug.
    a_free_only_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (free_vect & ~valid_vect) == '0);

`ifdef ISSUE_AGE_MATRIX_EN
    logic [QUEUE_DEPTH-1:0][QUEUE_DEPTH-1:0] age;
    logic [QUEUE_DEPTH-1:0][QUEUE_DEPTH-1:0] age_nxt;
    logic [QUEUE_DEPTH-1:0]                  lower_mask;
    logic [QUEUE_DEPTH-1:0]                  rdy_valid;
    logic                                    older_found;

    // A newly allocated slot is younger than everything already valid and
    // than slots granted to lower lanes in the same cycle. Freed slots keep
    // stale bits; they are overwritten when the slot is reallocated.
    always_comb begin
        age_nxt    = age;
        lower_mask = '0;
        if (flush) begin
            age_nxt = '0;
        end else begin
            for (int l = 0; l < ALLOC_WIDTH; l++) begin
                if (fs_gnt[l]) begin
                    for (int j = 0; j < QUEUE_DEPTH; j++) begin
                        age_nxt[j][fs_idx[l]] = valid_vect[j] | lower_mask[j];
                    end
                    age_nxt[fs_idx[l]]     = '0;
                    lower_mask[fs_idx[l]]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else begin
            age <= age_nxt;
        end
    end

    // A ready slot is oldest when no other ready slot is older than it.
    always_comb begin
        rdy_valid    = ready_vect & valid_vect;
        oldest_valid = 1'b0;
        oldest_idx   = '0;
        older_found  = 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (!oldest_valid && rdy_valid[i]) begin
                older_found = 1'b0;
                for (int j = 0; j < QUEUE_DEPTH; j++) begin
                    if (j != i && rdy_valid[j] && age[j][i]) begin
                        older_found = 1'b1;
                    end
                end
                if (!older_found) begin
                    oldest_valid = 1'b1;
                    oldest_idx   = i[IDX_W-1:0];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_issue_queue_alloc.sv
// ---------------------------------------------------------------------------
// tb_issue_queue_alloc
// Self-checking bench for issue_queue_alloc (depth 8, 2 lanes). A reference
// model holds per-slot occupancy and an allocation sequence number; grants
// are taken from a list of free slots, and the oldest ready slot is the
// ready valid slot with the smallest sequence number.
// ---------------------------------------------------------------------------
module tb_issue_queue_alloc;

    localparam int D  = 8;
    localparam int W  = 2;
    localparam int IW = 3;
    localparam int OW = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [W-1:0]           alloc_req;
    logic [W-1:0]           alloc_gnt;
    logic [W-1:0][IW-1:0]   alloc_idx;
    logic [D-1:0]           free_vect;
    logic                   flush;
    logic [D-1:0]           valid_vect;
    logic [OW-1:0]          occupancy;
    logic                   queue_full;
    logic                   can_accept;
`ifdef ISSUE_AGE_MATRIX_EN
    logic [D-1:0]           ready_vect;
    logic                   oldest_valid;
    logic [IW-1:0]          oldest_idx;
`endif

    always #5 clk = ~clk;

    issue_queue_alloc #(.QUEUE_DEPTH(D), .ALLOC_WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_idx    (alloc_idx),
        .free_vect    (free_vect),
        .flush        (flush),
        .valid_vect   (valid_vect),
        .occupancy    (occupancy),
        .queue_full   (queue_full),
        .can_accept   (can_accept)
`ifdef ISSUE_AGE_MATRIX_EN
        ,
        .ready_vect   (ready_vect),
        .oldest_valid (oldest_valid),
        .oldest_idx   (oldest_idx)
`endif
    );

    int n_run  = 0;
    int n_fail = 0;

    // Reference model state
    bit          mv[D];
    int unsigned seqn[D];
    int unsigned seq_ctr = 0;
    bit          eg[W];
    int          ei[W];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [D-1:0] mvec();
        logic [D-1:0] v;
        for (int i = 0; i < D; i++) v[i] = mv[i];
        return v;
    endfunction

    function automatic int m_occ();
        int c = 0;
        for (int i = 0; i < D; i++) c += int'(mv[i]);
        return c;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < D; i++) mv[i] = 1'b0;
    endfunction

    // Free slots are handed out in ascending order to requesting lanes;
    // the first requesting lane left without a slot stops all later lanes.
    function automatic void model_grants();
        int fl[$];
        int used = 0;
        bit stop = 1'b0;
        for (int i = 0; i < D; i++) if (!mv[i]) fl.push_back(i);
        for (int l = 0; l < W; l++) begin
            eg[l] = 1'b0;
            ei[l] = 0;
            if (alloc_req[l]) begin
                if (!stop && used < fl.size()) begin
                    eg[l] = 1'b1;
                    ei[l] = fl[used];
                    used++;
                end else begin
                    stop = 1'b1;
                end
            end
        end
    endfunction

    task automatic eval(input string tag);
        int occ;
        @(negedge clk);
        model_grants();
        occ = m_occ();
        for (int l = 0; l < W; l++) begin
            chk($sformatf("%s_gnt%0d", tag, l), 32'(alloc_gnt[l]), 32'(eg[l]));
            chk($sformatf("%s_idx%0d", tag, l), 32'(alloc_idx[l]), 32'(ei[l]));
        end
        chk({tag, "_valid"}, 32'(valid_vect), 32'(mvec()));
        chk({tag, "_occ"},   32'(occupancy),  32'(occ));
        chk({tag, "_full"},  32'(queue_full), 32'(occ == D));
        chk({tag, "_acc"},   32'(can_accept), 32'((D - occ) >= W));
`ifdef ISSUE_AGE_MATRIX_EN
        begin
            bit          ov = 1'b0;
            int          oi = 0;
            int unsigned best = 0;
            for (int i = 0; i < D; i++) begin
                if (mv[i] && ready_vect[i] && (!ov || seqn[i] < best)) begin
                    ov   = 1'b1;
                    oi   = i;
                    best = seqn[i];
                end
            end
            chk({tag, "_ovld"}, 32'(oldest_valid), 32'(ov));
            if (ov) chk({tag, "_oidx"}, 32'(oldest_idx), 32'(oi));
        end
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (flush) begin
            model_clear();
        end else begin
            for (int i = 0; i < D; i++) if (free_vect[i]) mv[i] = 1'b0;
            for (int l = 0; l < W; l++) begin
                if (eg[l]) begin
                    mv[ei[l]]   = 1'b1;
                    seqn[ei[l]] = seq_ctr;
                    seq_ctr++;
                end
            end
        end
        #1;
    endtask

    task automatic step(input string tag);
        eval(tag);
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        alloc_req = '0;
        free_vect = '0;
        flush     = 1'b0;
`ifdef ISSUE_AGE_MATRIX_EN
        ready_vect = '0;
`endif
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        alloc_req = 2'b11;
        #1;
        chk("rst_gnt",   32'(alloc_gnt),  32'h0);
        chk("rst_valid", 32'(valid_vect), 32'h0);
        chk("rst_occ",   32'(occupancy),  32'h0);
        chk("rst_full",  32'(queue_full), 32'h0);
        chk("rst_acc",   32'(can_accept), 32'h1);
`ifdef ISSUE_AGE_MATRIX_EN
        chk("rst_ovld",  32'(oldest_valid), 32'h0);
`endif
        rst_n = 1'b1;

        // Two lanes on an empty queue
        alloc_req = 2'b11;
        eval("idle");
        chk("idle_gnt",  32'(alloc_gnt),    32'h3);
        chk("idle_idx0", 32'(alloc_idx[0]), 32'h0);
        chk("idle_idx1", 32'(alloc_idx[1]), 32'h1);
        tick();

        // Allocate while freeing slot 1: slot 1 is not re-grantable yet
        alloc_req = 2'b01;
        free_vect = 8'h02;
        eval("alfr");
        chk("alfr_valid", 32'(valid_vect),   32'h03);
        chk("alfr_occ",   32'(occupancy),    32'h2);
        chk("alfr_idx0",  32'(alloc_idx[0]), 32'h2);
        tick();

        // Skip lane
        alloc_req = 2'b10;
        free_vect = '0;
        eval("skip");
        chk("skip_valid", 32'(valid_vect),   32'h05);
        chk("skip_gnt",   32'(alloc_gnt),    32'h2);
        chk("skip_idx1",  32'(alloc_idx[1]), 32'h1);
        chk("skip_idx0",  32'(alloc_idx[0]), 32'h0);
        tick();

        // Fill to 7, partial capacity, then full
        alloc_req = 2'b11;
        step("fill_a");
        step("fill_b");
        eval("part");
        chk("part_occ", 32'(occupancy),  32'h7);
        chk("part_gnt", 32'(alloc_gnt),  32'h1);
        chk("part_acc", 32'(can_accept), 32'h0);
        tick();

        free_vect = 8'h10;
        eval("full");
        chk("full_full", 32'(queue_full), 32'h1);
        chk("full_gnt",  32'(alloc_gnt),  32'h0);
        tick();

        free_vect = '0;
        eval("refill");
        chk("refill_gnt",  32'(alloc_gnt),    32'h1);
        chk("refill_idx0", 32'(alloc_idx[0]), 32'h4);
        chk("refill_occ",  32'(occupancy),    32'h7);
        tick();

        // Flush with simultaneous alloc and free
        alloc_req = 2'b00;
        free_vect = 8'h03;
        step("prefl");
        alloc_req = 2'b11;
        free_vect = 8'h04;
        flush     = 1'b1;
        step("flush");
        flush     = 1'b0;
        free_vect = '0;
        alloc_req = '0;
        eval("postfl");
        chk("postfl_valid", 32'(valid_vect), 32'h0);
        chk("postfl_occ",   32'(occupancy),  32'h0);
        tick();

        // Asynchronous reset between clock edges
        alloc_req = 2'b11;
        step("pre_ar_a");
        step("pre_ar_b");
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(valid_vect), 32'h0);
        chk("ar_occ",   32'(occupancy),  32'h0);
        chk("ar_full",  32'(queue_full), 32'h0);
        chk("ar_acc",   32'(can_accept), 32'h1);
        chk("ar_gnt",   32'(alloc_gnt),  32'h0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef ISSUE_AGE_MATRIX_EN
        // Build allocation order 3, 0, 5 among surviving slots
        alloc_req = 2'b11;
        repeat (4) step("age_fill");
        alloc_req = 2'b00;
        free_vect = 8'hF7;
        step("age_keep3");
        free_vect = '0;
        alloc_req = 2'b11;
        step("age_a01");
        step("age_a24");
        alloc_req = 2'b01;
        step("age_a5");
        alloc_req = 2'b00;
        free_vect = 8'h16;
        step("age_trim");
        free_vect  = '0;
        ready_vect = 8'h29;
        eval("age3");
        chk("age3_valid", 32'(valid_vect),   32'h29);
        chk("age3_ovld",  32'(oldest_valid), 32'h1);
        chk("age3_oidx",  32'(oldest_idx),   32'h3);
        free_vect = 8'h08;
        tick();
        free_vect = '0;
        eval("age0");
        chk("age0_oidx", 32'(oldest_idx), 32'h0);
        ready_vect = '0;
        eval("agenone");
        chk("agenone_ovld", 32'(oldest_valid), 32'h0);
        tick();
`endif

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            alloc_req = W'($urandom_range(0, 3));
            free_vect = (($urandom_range(0, 2) == 0) ? mvec() & D'($urandom) : '0);
            flush     = ($urandom_range(0, 24) == 0);
`ifdef ISSUE_AGE_MATRIX_EN
            ready_vect = D'($urandom);
`endif
            step("rnd");
        end
        flush     = 1'b0;
        alloc_req = '0;
        free_vect = '0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_queue_alloc.md
# issue_queue_alloc

Multi-lane slot allocator for the reservation-station issue queues, sitting between rename/dispatch and each issue queue. It owns the queue's valid vector and grants up to ALLOC_WIDTH free slots per cycle, lowest index first. It releases slots on issue or flush and keeps an occupancy count. Optionally it maintains an age matrix and reports the oldest ready slot to the select logic.

## Interface
Parameters:
- QUEUE_DEPTH, 8: number of slots; any value ≥ 2, not necessarily a power of two.
- ALLOC_WIDTH, 2: dispatch lanes per cycle, 1..QUEUE_DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alloc_req  in  ALLOC_WIDTH  per-lane allocation request. Lane 0 is the oldest instruction.
- alloc_gnt  out  ALLOC_WIDTH  per-lane grant.
- alloc_idx  out  ALLOC_WIDTH x IDX_W  granted slot per lane; IDX_W = $clog2(QUEUE_DEPTH).
- free_vect  in  QUEUE_DEPTH  slots leaving the queue this cycle (issued).
- flush  in  1  invalidate all slots.
- valid_vect  out  QUEUE_DEPTH  registered slot occupancy.
- occupancy  out  $clog2(QUEUE_DEPTH+1)  registered count of valid slots.
- queue_full  out  1  all slots valid.
- can_accept  out  1  free slot count ≥ ALLOC_WIDTH.
- ready_vect  in  QUEUE_DEPTH  operands-ready per slot. Present only with the age matrix.
- oldest_valid, oldest_idx  out  1, IDX_W  oldest ready slot. Present only with the age matrix.

## Operation
- Grants are combinational from the registered valid_vect and alloc_req.
  - Lane l is granted only if alloc_req[l] is set, every lane below l that requests is also granted, and an unused free slot remains.
  - Lane l takes the (n+1)-th lowest free slot, where n is the number of grants to lanes below l.
  - A non-requesting lane consumes no slot and does not block higher lanes.
- When alloc_gnt[l] is 0, alloc_idx[l] is 0.
- Next-state valid_vect = (valid_vect & ~free_vect) | granted slots.
  - A slot freed this cycle is not re-grantable until the following cycle, because grants use the current valid_vect.
  - free_vect bits on invalid slots are ignored. The simulation assertion flags them.
- flush has priority: next valid_vect = 0 and occupancy = 0. Grants are still driven combinationally but are discarded (not written).
- occupancy is registered: next value = popcount of next valid_vect. A simultaneous free and allocate nets out correctly.
- queue_full = &valid_vect.
- can_accept = (QUEUE_DEPTH − occupancy) ≥ ALLOC_WIDTH.

## Timing
- Reset (rst_n low, asynchronous): valid_vect = 0, occupancy = 0, queue_full = 0, can_accept = 1, and the age matrix is cleared.
  - alloc_gnt and oldest_valid are forced to 0 while rst_n is low.
  - Deassertion is synchronised by the top level; the block samples inputs from the first rising edge with rst_n high.
- Allocation: the grant is visible in the same cycle as the request. The slot shows in valid_vect and occupancy one cycle later.
- Free: the slot clears at the next edge. occupancy reflects it one cycle later.
- Full: all grants are 0. If free_vect frees k slots this cycle, up to k grants are possible next cycle.
- The handshake has no backpressure beyond grants. Dispatch must hold any ungranted lane and every lane above it.

## Configuration
- ISSUE_AGE_MATRIX_EN defined:
  - Adds ready_vect, oldest_valid, oldest_idx and a QUEUE_DEPTH² age register. age[i][j] = 1 means slot i is older than slot j.
  - On allocating slot k in lane l: column k is set for every currently valid slot and for the slots granted to lanes < l, and row k is cleared.
  - Freed slots need no update. Flush clears the matrix.
  - Oldest-ready is combinational: slot i qualifies if ready & valid and no other ready & valid j has age[j][i] set. oldest_valid is 0 if no slot is ready.
- ISSUE_AGE_MATRIX_EN undefined: the age ports and storage are absent, and select logic falls back to lowest-index priority.

## Structure
- rv32i_types gains the constant ISSUE_ALLOC_WIDTH. It has no typedefs.
- One sub-module, free_slot_finder: combinational. Inputs are a free mask and a lane request vector; outputs are per-lane grant and index, via a cascaded lowest-set-bit search.
- Registers, counter, flush handling and the age matrix live in issue_queue_alloc.

## Test plan
- Reset then idle: alloc_req = 2'b11 on an empty depth-8 queue → gnt = 11, idx = {0,1}. Next cycle valid_vect = 0x03, occupancy = 2.
- Skip lane: valid_vect = 0x05, alloc_req = 2'b10 → lane 1 granted slot 1, lane 0 gnt = 0, idx 0.
- Full plus free: fill all 8 slots, then assert free_vect = 0x10 with alloc_req = 2'b11.
  - That cycle: gnt = 00.
  - Next cycle: gnt = 01, idx[0] = 4, occupancy = 7.
- Partial capacity: occupancy = 7, alloc_req = 2'b11 → gnt = 01 and can_accept was 0. Next cycle queue_full = 1.
- Flush with simultaneous alloc and free → next cycle valid_vect = 0, occupancy = 0. Asynchronous rst_n mid-stream → outputs cleared immediately, without a clock edge.
- Age (macro on):
  - Allocate slots in the order 3, 0, 5; set ready_vect = 0x29 → oldest_idx = 3.
  - Free slot 3 → oldest_idx = 0.
  - Set ready_vect = 0 → oldest_valid = 0.
